// File: rtl/core_pkg.sv
// Shared encodings for the multicycle core: opcodes, FSM states, ALU control.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package core_pkg;

  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_IMM = 7'b0010011;
  localparam logic [6:0] OP_LD  = 7'b0000011;
  localparam logic [6:0] OP_ST  = 7'b0100011;
  localparam logic [6:0] OP_BR  = 7'b1100011;

  localparam logic [2:0] F3_ADD = 3'b000;
  localparam logic [2:0] F3_AND = 3'b111;
  localparam logic [2:0] F3_OR  = 3'b110;
  localparam logic [2:0] F3_D   = 3'b011;
  localparam logic [2:0] F3_BEQ = 3'b000;

  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_SUB  = 7'b0100000;

  typedef enum logic [2:0] {FETCH, DECODE, EXEC, MEM, WB, HALT} state_e;
  typedef enum logic [1:0] {ALU_ADD, ALU_SUB, ALU_AND, ALU_OR} alu_ctrl_e;
  typedef enum logic [1:0] {SRCB_REG, SRCB_IMM_I, SRCB_IMM_S} srcb_e;
  typedef enum logic {PC_NEXT, PC_TARGET} pc_sel_e;
  typedef enum logic {WB_ALU, WB_MDR} wb_sel_e;

  // R-type ALU control; funct7 only distinguishes sub from add.
  function automatic alu_ctrl_e alu_decode(input logic [2:0] f3, input logic [6:0] f7);
    alu_ctrl_e r;
    if (f7 == F7_SUB) begin
      r = ALU_SUB;
    end else begin
      case (f3)
        F3_AND:  r = ALU_AND;
        F3_OR:   r = ALU_OR;
        default: r = ALU_ADD;
      endcase
    end
    return r;
  endfunction

endpackage

// File: rtl/multicycle_core_if.sv
// Instruction and data memory ports of the multicycle core (req/valid handshake).
// Latency: a transfer completes in the first cycle where req and valid are both high.
// Backpressure: memory stalls by withholding valid; the core holds req/addr/we/wdata.
interface multicycle_core_if #(parameter int XLEN = 64) ();
  logic            imem_req;
  logic [XLEN-1:0] imem_addr;
  logic [31:0]     imem_rdata;
  logic            imem_valid;
  logic            dmem_req;
  logic            dmem_we;
  logic [XLEN-1:0] dmem_addr;
  logic [XLEN-1:0] dmem_wdata;
  logic [XLEN-1:0] dmem_rdata;
  logic            dmem_valid;

  modport master (
    output imem_req, imem_addr, input imem_rdata, imem_valid,
    output dmem_req, dmem_we, dmem_addr, dmem_wdata, input dmem_rdata, dmem_valid
  );

  modport slave (
    input imem_req, imem_addr, output imem_rdata, imem_valid,
    input dmem_req, dmem_we, dmem_addr, dmem_wdata, output dmem_rdata, dmem_valid
  );
endinterface

// File: rtl/core_ctrl.sv
// Controller FSM and instruction decode; drives every datapath enable and mux select.
// Latency: FETCH/DECODE/EXEC[/MEM][/WB], one state per clock plus memory wait cycles.
// Backpressure: FETCH and MEM hold their request until the matching valid arrives.
module core_ctrl
  import core_pkg::*;
(
  input  logic      clk,
  input  logic      reset,
  input  logic [6:0] i_opcode,
  input  logic [2:0] i_funct3,
  input  logic [6:0] i_funct7,
  input  logic      i_imem_valid,
  input  logic      i_dmem_valid,
  input  logic      i_eq,
  output logic      o_ir_we,
  output logic      o_ab_we,
  output logic      o_target_we,
  output logic      o_alu_out_we,
  output logic      o_mdr_we,
  output logic      o_rf_we,
  output logic      o_pc_we,
  output pc_sel_e   o_pc_sel,
  output wb_sel_e   o_wb_sel,
  output alu_ctrl_e o_alu_ctrl,
  output srcb_e     o_srcb,
  output logic      o_imem_req,
  output logic      o_dmem_req,
  output logic      o_dmem_we,
  output logic      o_retire,
  output logic      o_halted
);

  state_e r_state;
  state_e w_next;

  logic w_is_r, w_is_imm, w_is_ld, w_is_st, w_is_br, w_legal;

  assign w_is_r   = (i_opcode == OP_R);
  assign w_is_imm = (i_opcode == OP_IMM);
  assign w_is_ld  = (i_opcode == OP_LD);
  assign w_is_st  = (i_opcode == OP_ST);
  assign w_is_br  = (i_opcode == OP_BR);

  assign w_legal =
      (w_is_r && (((i_funct7 == F7_BASE) &&
                   ((i_funct3 == F3_ADD) || (i_funct3 == F3_AND) || (i_funct3 == F3_OR))) ||
                  ((i_funct7 == F7_SUB) && (i_funct3 == F3_ADD)))) ||
      (w_is_imm && (i_funct3 == F3_ADD)) ||
      (w_is_ld  && (i_funct3 == F3_D))   ||
      (w_is_st  && (i_funct3 == F3_D))   ||
      (w_is_br  && (i_funct3 == F3_BEQ));

  // State register; reset returns to FETCH from anywhere, including HALT.
  always_ff @(posedge clk) begin
    if (reset) r_state <= FETCH;
    else       r_state <= w_next;
  end

  // Next state and per-state controls; everything stays quiet while reset is high.
  always_comb begin
    w_next       = r_state;
    o_ir_we      = 1'b0;
    o_ab_we      = 1'b0;
    o_target_we  = 1'b0;
    o_alu_out_we = 1'b0;
    o_mdr_we     = 1'b0;
    o_rf_we      = 1'b0;
    o_pc_we      = 1'b0;
    o_pc_sel     = PC_NEXT;
    o_wb_sel     = WB_ALU;
    o_alu_ctrl   = ALU_ADD;
    o_srcb       = SRCB_REG;
    o_imem_req   = 1'b0;
    o_dmem_req   = 1'b0;
    o_dmem_we    = 1'b0;
    o_retire     = 1'b0;
    o_halted     = 1'b0;
    if (!reset) begin
      case (r_state)
        FETCH: begin
          o_imem_req = 1'b1;
          if (i_imem_valid) begin
            o_ir_we = 1'b1;
            w_next  = DECODE;
          end
        end
        DECODE: begin
          if (!w_legal) begin
            w_next = HALT;
          end else begin
            o_ab_we     = 1'b1;
            o_target_we = 1'b1;
            w_next      = EXEC;
          end
        end
        EXEC: begin
          o_alu_out_we = 1'b1;
          if (w_is_r)       o_alu_ctrl = alu_decode(i_funct3, i_funct7);
          if (w_is_r)       o_srcb = SRCB_REG;
          else if (w_is_st) o_srcb = SRCB_IMM_S;
          else              o_srcb = SRCB_IMM_I;
          if (w_is_br) begin
            o_pc_we  = 1'b1;
            o_pc_sel = i_eq ? PC_TARGET : PC_NEXT;
            o_retire = 1'b1;
            w_next   = FETCH;
          end else if (w_is_ld || w_is_st) begin
            w_next = MEM;
          end else begin
            w_next = WB;
          end
        end
        MEM: begin
          o_dmem_req = 1'b1;
          o_dmem_we  = w_is_st;
          if (i_dmem_valid) begin
            if (w_is_st) begin
              o_pc_we  = 1'b1;
              o_retire = 1'b1;
              w_next   = FETCH;
            end else begin
              o_mdr_we = 1'b1;
              w_next   = WB;
            end
          end
        end
        WB: begin
          o_rf_we  = 1'b1;
          o_wb_sel = w_is_ld ? WB_MDR : WB_ALU;
          o_pc_we  = 1'b1;
          o_retire = 1'b1;
          w_next   = FETCH;
        end
        default: begin
          o_halted = 1'b1;
          w_next   = HALT;
        end
      endcase
    end
  end

endmodule

// File: rtl/multicycle_core.sv
// Multicycle RV64-subset core: datapath (PC, IR, A, B, ALUOut, MDR, regfile, ALU) plus core_ctrl.
// Latency: R/addi 4, ld 5, sd 4, beq 3 clocks with zero-wait memories; +1 per wait cycle.
// Backpressure: imem/dmem stall the core by withholding valid; requests stay stable meanwhile.
module multicycle_core
  import core_pkg::*;
#(
  parameter int              XLEN     = 64,
  parameter int              NREGS    = 32,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic               clk,
  input  logic               reset,
  multicycle_core_if.master  bus,
  output logic               retire,
  output logic               halted
);

  logic [XLEN-1:0] r_pc, r_a, r_b, r_target, r_alu_out, r_mdr;
  logic [31:0]     r_ir;
  logic [XLEN-1:0] r_rf [NREGS];

  logic w_ir_we, w_ab_we, w_target_we, w_alu_out_we, w_mdr_we, w_rf_we, w_pc_we;
  logic w_imem_req, w_dmem_req, w_dmem_we;
  pc_sel_e   w_pc_sel;
  wb_sel_e   w_wb_sel;
  alu_ctrl_e w_alu_ctrl;
  srcb_e     w_srcb;

  logic [4:0]      w_rs1, w_rs2, w_rd;
  logic [XLEN-1:0] w_rs1_dat, w_rs2_dat, w_imm_i, w_imm_s, w_imm_b;
  logic [XLEN-1:0] w_alu_b, w_alu_res, w_wb_dat, w_pc4;
  logic            w_eq;

  assign w_rs1 = r_ir[19:15];
  assign w_rs2 = r_ir[24:20];
  assign w_rd  = r_ir[11:7];

  assign w_imm_i = {{(XLEN-12){r_ir[31]}}, r_ir[31:20]};
  assign w_imm_s = {{(XLEN-12){r_ir[31]}}, r_ir[31:25], r_ir[11:7]};
  assign w_imm_b = {{(XLEN-13){r_ir[31]}}, r_ir[31], r_ir[7], r_ir[30:25], r_ir[11:8], 1'b0};

  assign w_rs1_dat = (w_rs1 == 5'd0) ? '0 : r_rf[w_rs1];
  assign w_rs2_dat = (w_rs2 == 5'd0) ? '0 : r_rf[w_rs2];
  assign w_eq      = (r_a == r_b);
  assign w_pc4     = r_pc + XLEN'(4);
  assign w_wb_dat  = (w_wb_sel == WB_MDR) ? r_mdr : r_alu_out;

  core_ctrl u_ctrl (
    .clk          (clk),
    .reset        (reset),
    .i_opcode     (r_ir[6:0]),
    .i_funct3     (r_ir[14:12]),
    .i_funct7     (r_ir[31:25]),
    .i_imem_valid (bus.imem_valid),
    .i_dmem_valid (bus.dmem_valid),
    .i_eq         (w_eq),
    .o_ir_we      (w_ir_we),
    .o_ab_we      (w_ab_we),
    .o_target_we  (w_target_we),
    .o_alu_out_we (w_alu_out_we),
    .o_mdr_we     (w_mdr_we),
    .o_rf_we      (w_rf_we),
    .o_pc_we      (w_pc_we),
    .o_pc_sel     (w_pc_sel),
    .o_wb_sel     (w_wb_sel),
    .o_alu_ctrl   (w_alu_ctrl),
    .o_srcb       (w_srcb),
    .o_imem_req   (w_imem_req),
    .o_dmem_req   (w_dmem_req),
    .o_dmem_we    (w_dmem_we),
    .o_retire     (retire),
    .o_halted     (halted)
  );

  assign bus.imem_req   = w_imem_req;
  assign bus.imem_addr  = r_pc;
  assign bus.dmem_req   = w_dmem_req;
  assign bus.dmem_we    = w_dmem_we;
  assign bus.dmem_addr  = r_alu_out;
  assign bus.dmem_wdata = r_b;

  // Second ALU operand: rs2 for R-type, I-immediate for addi/ld, S-immediate for sd.
  always_comb begin
    w_alu_b = r_b;
    case (w_srcb)
      SRCB_IMM_I: w_alu_b = w_imm_i;
      SRCB_IMM_S: w_alu_b = w_imm_s;
      default:    w_alu_b = r_b;
    endcase
  end

  // ALU; all arithmetic wraps modulo 2^XLEN.
  always_comb begin
    w_alu_res = r_a + w_alu_b;
    case (w_alu_ctrl)
      ALU_SUB: w_alu_res = r_a - w_alu_b;
      ALU_AND: w_alu_res = r_a & w_alu_b;
      ALU_OR:  w_alu_res = r_a | w_alu_b;
      default: w_alu_res = r_a + w_alu_b;
    endcase
  end

  // PC: advanced only when an instruction commits, so imem_addr is stable through FETCH.
  always_ff @(posedge clk) begin
    if (reset)        r_pc <= RESET_PC;
    else if (w_pc_we) r_pc <= (w_pc_sel == PC_TARGET) ? r_target : w_pc4;
  end

  // Pipeline-less staging registers between FSM states.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_ir      <= '0;
      r_a       <= '0;
      r_b       <= '0;
      r_target  <= '0;
      r_alu_out <= '0;
      r_mdr     <= '0;
    end else begin
      if (w_ir_we)      r_ir      <= bus.imem_rdata;
      if (w_ab_we)      r_a       <= w_rs1_dat;
      if (w_ab_we)      r_b       <= w_rs2_dat;
      if (w_target_we)  r_target  <= r_pc + w_imm_b;
      if (w_alu_out_we) r_alu_out <= w_alu_res;
      if (w_mdr_we)     r_mdr     <= bus.dmem_rdata;
    end
  end

  // Register file; writes to x0 are dropped so it always reads back zero.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NREGS; i++) r_rf[i] <= '0;
    end else if (w_rf_we && (w_rd != 5'd0)) begin
      r_rf[w_rd] <= w_wb_dat;
    end
  end

endmodule

// File: tb/tb_multicycle_core.sv
// Scoreboard bench: expected fetches, data accesses and retire spacing queued up front.
// Latency: memory responders add programmable wait states per access.
// Backpressure: responders withhold valid for the configured number of req cycles.
module tb_multicycle_core;

  logic clk;
  logic reset;
  logic retire;
  logic halted;

  multicycle_core_if #(.XLEN(64)) bus ();

  multicycle_core #(.XLEN(64), .NREGS(32), .RESET_PC(64'h0)) dut (
    .clk    (clk),
    .reset  (reset),
    .bus    (bus),
    .retire (retire),
    .halted (halted)
  );

  typedef struct {
    logic        we;
    logic [63:0] addr;
    logic [63:0] wdata;
  } dexp_t;

  logic [63:0] q_fetch [$];
  int          q_ret   [$];
  dexp_t       q_dmem  [$];

  logic [31:0] imem [32];
  logic [63:0] dmem [16];

  int n_tests = 0;
  int n_fail  = 0;
  int cyc = 0;
  int last_ret = 0;
  int last_fetch_cyc = 0;
  int imem_wait = 0;
  int dmem_wait = 0;
  int icnt = 0;
  int dcnt = 0;
  logic inj_ivalid = 1'b0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [31:0] enc_i(input logic [11:0] imm, input logic [4:0] rs1,
                                        input logic [2:0] f3, input logic [4:0] rd,
                                        input logic [6:0] op);
    return {imm, rs1, f3, rd, op};
  endfunction

  function automatic logic [31:0] enc_s(input logic [11:0] imm, input logic [4:0] rs2,
                                        input logic [4:0] rs1);
    return {imm[11:5], rs2, rs1, 3'b011, imm[4:0], 7'b0100011};
  endfunction

  function automatic logic [31:0] enc_r(input logic [6:0] f7, input logic [4:0] rs2,
                                        input logic [4:0] rs1, input logic [2:0] f3,
                                        input logic [4:0] rd);
    return {f7, rs2, rs1, f3, rd, 7'b0110011};
  endfunction

  function automatic logic [31:0] enc_b(input logic [12:0] imm, input logic [4:0] rs2,
                                        input logic [4:0] rs1);
    return {imm[12], imm[10:5], rs2, rs1, 3'b000, imm[4:1], imm[11], 7'b1100011};
  endfunction

  // Place an instruction and queue its fetch plus expected clocks-per-instruction (0 = no retire).
  task automatic ins(input int pc, input logic [31:0] w, input int cpi);
    imem[pc/4] = w;
    q_fetch.push_back(64'(pc));
    if (cpi > 0) q_ret.push_back(cpi);
  endtask

  task automatic dexp(input logic we, input logic [63:0] a, input logic [63:0] d);
    dexp_t e;
    e.we = we; e.addr = a; e.wdata = d;
    q_dmem.push_back(e);
  endtask

  // One reset cycle; outputs must be quiet during it. Optionally injects a stray imem_valid.
  task automatic do_reset(input logic inject);
    @(posedge clk); #1;
    reset = 1'b1;
    inj_ivalid = inject;
    @(negedge clk); #1;
    check("reset_outputs", {59'd0, bus.imem_req, bus.dmem_req, bus.dmem_we, retire, halted}, 64'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    inj_ivalid = 1'b0;
    last_ret = cyc - 1;
  endtask

  task automatic wait_drain(input int bound);
    for (int i = 0; i < bound; i++) begin
      @(negedge clk); #2;
      if (q_fetch.size() + q_ret.size() + q_dmem.size() == 0) break;
    end
    check("queues_drained", 64'(q_fetch.size() + q_ret.size() + q_dmem.size()), 64'd0);
  endtask

  // Memory responders: valid rises once req has been held for the configured wait count.
  initial begin
    bus.imem_valid = 1'b0;
    bus.imem_rdata = '0;
    bus.dmem_valid = 1'b0;
    bus.dmem_rdata = '0;
    forever begin
      @(negedge clk);
      if (bus.imem_req) begin
        bus.imem_valid = (icnt == imem_wait);
        bus.imem_rdata = imem[bus.imem_addr[6:2]];
        icnt = bus.imem_valid ? 0 : icnt + 1;
      end else begin
        bus.imem_valid = 1'b0;
        icnt = 0;
      end
      if (inj_ivalid) begin
        bus.imem_valid = 1'b1;
        bus.imem_rdata = 32'hFFFF_FFFF;
      end
      if (bus.dmem_req) begin
        bus.dmem_valid = (dcnt == dmem_wait);
        bus.dmem_rdata = dmem[bus.dmem_addr[6:3]];
        if (bus.dmem_valid && bus.dmem_we) dmem[bus.dmem_addr[6:3]] = bus.dmem_wdata;
        dcnt = bus.dmem_valid ? 0 : dcnt + 1;
      end else begin
        bus.dmem_valid = 1'b0;
        dcnt = 0;
      end
    end
  end

  // Monitor: pops expectations whenever a transfer completes or an instruction retires.
  initial begin
    forever begin
      @(negedge clk); #1;
      if (bus.imem_req && bus.imem_valid) begin
        if (q_fetch.size() == 0) check("fetch_unexpected", bus.imem_addr, 64'hDEAD);
        else check("fetch_addr", bus.imem_addr, q_fetch.pop_front());
        last_fetch_cyc = cyc;
      end
      if (bus.dmem_req && bus.dmem_valid) begin
        if (q_dmem.size() == 0) begin
          check("dmem_unexpected", bus.dmem_addr, 64'hDEAD);
        end else begin
          dexp_t e;
          e = q_dmem.pop_front();
          check("dmem_we", {63'd0, bus.dmem_we}, {63'd0, e.we});
          check("dmem_addr", bus.dmem_addr, e.addr);
          if (e.we) check("dmem_wdata", bus.dmem_wdata, e.wdata);
        end
      end
      if (retire) begin
        if (q_ret.size() == 0) check("retire_unexpected", 64'(cyc - last_ret), 64'd0);
        else check("retire_cpi", 64'(cyc - last_ret), 64'(q_ret.pop_front()));
        last_ret = cyc;
      end
    end
  end

  initial begin
    int reqs;
    reset = 1'b1;
    for (int i = 0; i < 32; i++) imem[i] = 32'hFFFF_FFFF;
    for (int i = 0; i < 16; i++) dmem[i] = '0;
    imem_wait = 0;
    dmem_wait = 2;

    ins( 0, enc_i(12'd5,  5'd0, 3'b000, 5'd1, 7'b0010011), 4);   // addi x1,x0,5
    ins( 4, enc_i(12'd7,  5'd0, 3'b000, 5'd2, 7'b0010011), 4);   // addi x2,x0,7
    ins( 8, enc_r(7'h00, 5'd2, 5'd1, 3'b000, 5'd3), 4);          // add x3,x1,x2 = 12
    ins(12, enc_s(12'd16, 5'd3, 5'd0), 6);                       // sd x3,16(x0)
    dexp(1'b1, 64'd16, 64'd12);
    ins(16, enc_i(12'd16, 5'd0, 3'b011, 5'd4, 7'b0000011), 7);   // ld x4,16(x0)
    dexp(1'b0, 64'd16, 64'd0);
    ins(20, enc_s(12'd24, 5'd4, 5'd0), 6);                       // sd x4,24(x0)
    dexp(1'b1, 64'd24, 64'd12);
    ins(24, enc_b(13'd8, 5'd1, 5'd1), 3);                        // beq x1,x1,+8 taken
    ins(32, enc_b(13'd8, 5'd2, 5'd1), 3);                        // beq x1,x2,+8 not taken
    ins(36, enc_i(12'd9, 5'd0, 3'b000, 5'd0, 7'b0010011), 4);    // addi x0,x0,9
    ins(40, enc_r(7'h00, 5'd0, 5'd0, 3'b000, 5'd5), 4);          // add x5,x0,x0
    ins(44, enc_s(12'd32, 5'd5, 5'd0), 6);                       // sd x5,32(x0)
    dexp(1'b1, 64'd32, 64'd0);
    ins(48, enc_r(7'h20, 5'd1, 5'd2, 3'b000, 5'd6), 4);          // sub x6,x2,x1 = 2
    ins(52, enc_r(7'h00, 5'd2, 5'd1, 3'b111, 5'd7), 4);          // and x7 = 5
    ins(56, enc_r(7'h00, 5'd2, 5'd1, 3'b110, 5'd8), 4);          // or  x8 = 7
    ins(60, enc_s(12'd40, 5'd6, 5'd0), 6);
    dexp(1'b1, 64'd40, 64'd2);
    ins(64, enc_s(12'd48, 5'd7, 5'd0), 6);
    dexp(1'b1, 64'd48, 64'd5);
    ins(68, enc_s(12'd56, 5'd8, 5'd0), 6);
    dexp(1'b1, 64'd56, 64'd7);
    ins(72, enc_i(12'hFFD, 5'd0, 3'b000, 5'd9, 7'b0010011), 4);  // addi x9,x0,-3
    ins(76, enc_s(12'd64, 5'd9, 5'd0), 6);
    dexp(1'b1, 64'd64, 64'hFFFF_FFFF_FFFF_FFFD);
    ins(80, enc_i(12'd40, 5'd0, 3'b000, 5'd11, 7'b0010011), 4);  // addi x11,x0,40
    ins(84, enc_i(12'hFF0, 5'd11, 3'b011, 5'd12, 7'b0000011), 7);// ld x12,-16(x11)
    dexp(1'b0, 64'd24, 64'd0);
    ins(88, enc_s(12'd72, 5'd12, 5'd0), 6);                      // sd x12,72(x0)
    dexp(1'b1, 64'd72, 64'd12);
    ins(92, 32'hFFFF_FFFF, 0);                                   // illegal -> HALT

    do_reset(1'b0);
    @(negedge clk); #1;
    check("after_reset_halted", {63'd0, halted}, 64'd0);
    check("after_reset_imem_req", {63'd0, bus.imem_req}, 64'd1);

    for (int i = 0; i < 1000; i++) begin
      @(negedge clk); #2;
      if (halted) break;
    end
    check("halted_set", {63'd0, halted}, 64'd1);
    check("halt_after_decode", 64'(cyc - last_fetch_cyc), 64'd2);
    reqs = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk); #2;
      if (bus.imem_req) reqs++;
    end
    check("halt_no_imem_req", 64'(reqs), 64'd0);
    check("halt_sticky", {63'd0, halted}, 64'd1);
    wait_drain(1);

    imem_wait = 3;
    do_reset(1'b0);
    @(negedge clk); #1;
    check("reset_clears_halted", {63'd0, halted}, 64'd0);
    q_fetch.push_back(64'd0);  q_ret.push_back(7);
    q_fetch.push_back(64'd4);  q_ret.push_back(7);
    q_fetch.push_back(64'd8);  q_ret.push_back(7);
    q_fetch.push_back(64'd12); q_ret.push_back(9);
    dexp(1'b1, 64'd16, 64'd12);
    do_reset(1'b1);
    wait_drain(600);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, tests %0d failed %0d", n_tests, n_fail);
    $fatal(1);
  end

endmodule
